// File: rtl/xif_mem_responder_if.sv
// Bundles the coprocessor memory request/result channel and the data-bus channel of xif_mem_responder.
// The slave modport is the responder's view; the master modport is the environment's view (coprocessor + bus).
interface xif_mem_responder_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32
);
  typedef struct packed {
    logic [X_ID_WIDTH-1:0]    id;
    logic [31:0]              addr;
    logic [1:0]               mode;
    logic                     we;
    logic [2:0]               size;
    logic [X_MEM_WIDTH/8-1:0] be;
    logic [1:0]               attr;
    logic [X_MEM_WIDTH-1:0]   wdata;
    logic                     last;
    logic                     spec;
  } x_mem_req_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_result_t;

  logic                     mem_valid;
  logic                     mem_ready;
  x_mem_req_t               mem_req;
  logic                     mem_resp_exc;
  logic [5:0]               mem_resp_exc_code;
  logic                     mem_result_valid;
  x_mem_result_t            mem_result;

  logic                     bus_req;
  logic                     bus_gnt;
  logic [31:0]              bus_addr;
  logic                     bus_we;
  logic [X_MEM_WIDTH/8-1:0] bus_be;
  logic [X_MEM_WIDTH-1:0]   bus_wdata;
  logic                     bus_rvalid;
  logic [X_MEM_WIDTH-1:0]   bus_rdata;
  logic                     bus_err;

  modport slave (
    input  mem_valid, mem_req, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output mem_ready, mem_resp_exc, mem_resp_exc_code, mem_result_valid, mem_result,
           bus_req, bus_addr, bus_we, bus_be, bus_wdata
  );

  modport master (
    output mem_valid, mem_req, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  mem_ready, mem_resp_exc, mem_resp_exc_code, mem_result_valid, mem_result,
           bus_req, bus_addr, bus_we, bus_be, bus_wdata
  );
endinterface

// File: rtl/xif_mem_responder.sv
// Single-outstanding coprocessor memory responder: forwards one request to the data bus and returns one result.
// Define RVFPM_MISALIGN_CHK_EN to reject misaligned half/word accesses with an exception at handshake time.
module xif_mem_responder #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  xif_mem_responder_if.slave xif
);
  localparam int BE_W = X_MEM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, RESULT} state_e;

  state_e                 state_q, state_d;
  logic                   mem_ready_q, mem_ready_d;
  logic                   bus_req_q, bus_req_d;
  logic                   result_valid_q, result_valid_d;
  logic [X_ID_WIDTH-1:0]  id_q, id_d;
  logic [31:0]            addr_q, addr_d;
  logic                   we_q, we_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic [X_MEM_WIDTH-1:0] wdata_q, wdata_d;
  logic [X_MEM_WIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic hs;
  logic misaligned;
  logic exc;

  // mode, attr, last and spec carry no meaning for this responder.
`ifdef RVFPM_MISALIGN_CHK_EN
  logic unused_fields;
  assign unused_fields = ^{xif.mem_req.mode, xif.mem_req.attr, xif.mem_req.last, xif.mem_req.spec};
  assign misaligned = ((xif.mem_req.size == 3'd1) && xif.mem_req.addr[0]) ||
                      ((xif.mem_req.size == 3'd2) && (xif.mem_req.addr[1:0] != 2'b00));
`else
  logic unused_fields;
  assign unused_fields = ^{xif.mem_req.mode, xif.mem_req.attr, xif.mem_req.last,
                           xif.mem_req.spec, xif.mem_req.size};
  assign misaligned = 1'b0;
`endif

  assign hs  = xif.mem_valid && mem_ready_q;
  assign exc = hs && misaligned;

  always_comb begin
    state_d        = state_q;
    mem_ready_d    = mem_ready_q;
    bus_req_d      = bus_req_q;
    result_valid_d = result_valid_q;
    id_d           = id_q;
    addr_d         = addr_q;
    we_d           = we_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    case (state_q)
      IDLE: begin
        if (hs && !misaligned) begin
          id_d        = xif.mem_req.id;
          addr_d      = xif.mem_req.addr;
          we_d        = xif.mem_req.we;
          be_d        = xif.mem_req.be;
          wdata_d     = xif.mem_req.wdata;
          mem_ready_d = 1'b0;
          bus_req_d   = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (xif.bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (xif.bus_rvalid) begin
          // Stores return zero data regardless of what the bus drives back.
          rdata_d        = we_q ? '0 : xif.bus_rdata;
          err_d          = xif.bus_err;
          result_valid_d = 1'b1;
          state_d        = RESULT;
        end
      end
      RESULT: begin
        result_valid_d = 1'b0;
        mem_ready_d    = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d        = IDLE;
        mem_ready_d    = 1'b1;
        bus_req_d      = 1'b0;
        result_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_ready_q    <= 1'b1;
      bus_req_q      <= 1'b0;
      result_valid_q <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      be_q           <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_ready_q    <= mem_ready_d;
      bus_req_q      <= bus_req_d;
      result_valid_q <= result_valid_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
    end
  end

  assign xif.mem_ready         = mem_ready_q;
  assign xif.mem_resp_exc      = exc;
  assign xif.mem_resp_exc_code = exc ? (xif.mem_req.we ? 6'd6 : 6'd4) : 6'd0;
  assign xif.mem_result_valid  = result_valid_q;
  assign xif.mem_result        = '{id: id_q, rdata: rdata_q, err: err_q, dbg: 1'b0};

  assign xif.bus_req   = bus_req_q;
  assign xif.bus_addr  = addr_q;
  assign xif.bus_we    = we_q;
  assign xif.bus_be    = be_q;
  assign xif.bus_wdata = wdata_q;
endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder: load, stalled store, bus error, alignment, reset abort, back-to-back.
module tb_xif_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xif_mem_responder_if #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32)) xif ();

  xif_mem_responder #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .xif (xif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                         input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata);
    xif.mem_req       = '0;
    xif.mem_req.id    = id;
    xif.mem_req.addr  = addr;
    xif.mem_req.we    = we;
    xif.mem_req.size  = size;
    xif.mem_req.be    = be;
    xif.mem_req.wdata = wdata;
    xif.mem_req.spec  = 1'b1;
    xif.mem_req.mode  = 2'b11;
  endtask

  int res_ids[$];
  int res_cycle[$];
  int acc_cycle[$];

  initial begin
    xif.mem_valid  = 1'b0;
    xif.mem_req    = '0;
    xif.bus_gnt    = 1'b0;
    xif.bus_rvalid = 1'b0;
    xif.bus_rdata  = '0;
    xif.bus_err    = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    check("rst_ready", xif.mem_ready, 1'b1);
    check("rst_rvalid", xif.mem_result_valid, 1'b0);
    check("rst_bus_req", xif.bus_req, 1'b0);
    check("rst_result", xif.mem_result, '0);
    check("rst_exc", {xif.mem_resp_exc, xif.mem_resp_exc_code}, 7'd0);
    check("idle_hold", xif.mem_ready, 1'b1);

    // Load id=3 addr=0x100, immediate grant, rvalid next cycle
    set_req(4'd3, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0);
    xif.mem_valid = 1'b1;
    check("ld_hs_ready", xif.mem_ready, 1'b1);
    step();                                  // N+1
    xif.mem_valid = 1'b0;
    check("ld_bus", {xif.bus_req, xif.bus_we, xif.bus_addr, xif.mem_ready}, {1'b1, 1'b0, 32'h100, 1'b0});
    xif.bus_gnt = 1'b1;
    step();                                  // N+2
    xif.bus_gnt = 1'b0;
    check("ld_resp_bus_req", xif.bus_req, 1'b0);
    xif.bus_rvalid = 1'b1;
    xif.bus_rdata  = 32'hDEADBEEF;
    step();                                  // N+3
    xif.bus_rvalid = 1'b0;
    check("ld_result_valid", xif.mem_result_valid, 1'b1);
    check("ld_result", {xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err, xif.mem_result.dbg},
          {4'd3, 32'hDEADBEEF, 1'b0, 1'b0});
    step();                                  // N+4
    check("ld_pulse_end", {xif.mem_result_valid, xif.mem_ready}, 2'b01);

    // Store id=5 with grant held low 3 cycles
    set_req(4'd5, 32'h204, 1'b1, 3'd2, 4'hF, 32'h12345678);
    xif.mem_valid = 1'b1;
    step();
    xif.mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_bus_stable%0d", i),
            {xif.bus_req, xif.bus_we, xif.bus_be, xif.bus_addr, xif.bus_wdata},
            {1'b1, 1'b1, 4'hF, 32'h204, 32'h12345678});
      if (i == 3) xif.bus_gnt = 1'b1;
      step();
    end
    xif.bus_gnt    = 1'b0;
    xif.bus_rvalid = 1'b1;
    xif.bus_rdata  = 32'hAAAA5555;
    step();
    xif.bus_rvalid = 1'b0;
    check("st_result", {xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err},
          {1'b1, 4'd5, 32'h0, 1'b0});
    step();

    // Load id=7 with bus error
    set_req(4'd7, 32'h300, 1'b0, 3'd2, 4'hF, 32'h0);
    xif.mem_valid = 1'b1;
    step();
    xif.mem_valid = 1'b0;
    xif.bus_gnt   = 1'b1;
    step();
    xif.bus_gnt    = 1'b0;
    xif.bus_rvalid = 1'b1;
    xif.bus_rdata  = 32'h0BAD0BAD;
    xif.bus_err    = 1'b1;
    step();
    xif.bus_rvalid = 1'b0;
    xif.bus_err    = 1'b0;
    check("err_result", {xif.mem_result_valid, xif.mem_result.id, xif.mem_result.err}, {1'b1, 4'd7, 1'b1});
    step();
    check("err_ready_back", xif.mem_ready, 1'b1);

    // Misaligned word store addr=0x102
    set_req(4'd9, 32'h102, 1'b1, 3'd2, 4'hF, 32'hCAFEF00D);
    xif.mem_valid = 1'b1;
    #1;
`ifdef RVFPM_MISALIGN_CHK_EN
    check("mis_st_exc", {xif.mem_resp_exc, xif.mem_resp_exc_code}, {1'b1, 6'd6});
    step();
    xif.mem_valid = 1'b0;
    check("mis_st_idle", {xif.bus_req, xif.mem_ready, xif.mem_result_valid}, 3'b010);
    set_req(4'd10, 32'h101, 1'b0, 3'd1, 4'h3, 32'h0);
    xif.mem_valid = 1'b1;
    #1;
    check("mis_ld_exc", {xif.mem_resp_exc, xif.mem_resp_exc_code}, {1'b1, 6'd4});
    step();
    xif.mem_valid = 1'b0;
    step();
    check("mis_no_result", {xif.bus_req, xif.mem_ready, xif.mem_result_valid}, 3'b010);
`else
    check("mis_st_noexc", {xif.mem_resp_exc, xif.mem_resp_exc_code}, 7'd0);
    step();
    xif.mem_valid = 1'b0;
    check("mis_st_fwd", {xif.bus_req, xif.bus_addr, xif.bus_wdata}, {1'b1, 32'h102, 32'hCAFEF00D});
    xif.bus_gnt = 1'b1;
    step();
    xif.bus_gnt    = 1'b0;
    xif.bus_rvalid = 1'b1;
    step();
    xif.bus_rvalid = 1'b0;
    check("mis_st_result", {xif.mem_result_valid, xif.mem_result.id}, {1'b1, 4'd9});
    step();
`endif

    // Reset pulsed in RESP, then a late bus_rvalid
    set_req(4'd6, 32'h400, 1'b0, 3'd2, 4'hF, 32'h0);
    xif.mem_valid = 1'b1;
    step();
    xif.mem_valid = 1'b0;
    xif.bus_gnt   = 1'b1;
    step();
    xif.bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_abort_now", {xif.mem_ready, xif.bus_req, xif.mem_result_valid}, 3'b100);
    step();
    rst = 1'b0;
    xif.bus_rvalid = 1'b1;
    xif.bus_rdata  = 32'h55AA55AA;
    step();
    xif.bus_rvalid = 1'b0;
    check("rst_late_rvalid", {xif.mem_result_valid, xif.mem_ready, xif.bus_req}, 3'b010);
    step();
    check("rst_no_result", {xif.mem_result_valid, xif.mem_result.rdata, xif.mem_result.id}, {1'b0, 32'h0, 4'd0});

    // Back-to-back: mem_valid held, ids 1 then 2, bus answers as fast as allowed
    begin
      logic prev_hs;
      logic gnt_prev;
      int   cyc;
      prev_hs  = 1'b0;
      gnt_prev = 1'b0;
      set_req(4'd1, 32'h500, 1'b0, 3'd2, 4'hF, 32'h0);
      xif.mem_valid = 1'b1;
      for (cyc = 0; cyc < 40 && res_ids.size() < 2; cyc++) begin
        if (prev_hs) begin
          if (acc_cycle.size() == 1) xif.mem_req.id = 4'd2;
          else xif.mem_valid = 1'b0;
        end
        xif.bus_rvalid = gnt_prev;
        xif.bus_rdata  = 32'hA000 + 32'(acc_cycle.size());
        gnt_prev       = xif.bus_req;
        xif.bus_gnt    = xif.bus_req;
        if (xif.mem_result_valid) begin
          res_ids.push_back(int'(xif.mem_result.id));
          res_cycle.push_back(cyc);
        end
        prev_hs = xif.mem_valid && xif.mem_ready;
        if (prev_hs) acc_cycle.push_back(cyc);
        step();
      end
      xif.mem_valid  = 1'b0;
      xif.bus_gnt    = 1'b0;
      xif.bus_rvalid = 1'b0;
      check("b2b_count", res_ids.size(), 2);
      if (res_ids.size() == 2 && acc_cycle.size() == 2) begin
        check("b2b_first_id", res_ids[0], 1);
        check("b2b_second_id", res_ids[1], 2);
        check("b2b_second_after_first", acc_cycle[1] > res_cycle[0], 1'b1);
      end else begin
        check("b2b_accepts", acc_cycle.size(), 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, instruction ID width.
REQ-002 Parameter X_MEM_WIDTH, default 32, data width; byte-enable width is X_MEM_WIDTH/8.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 mem_valid  in  1  coprocessor memory request valid.
REQ-006 mem_ready  out  1  responder accepts request.
REQ-007 mem_req  in  x_mem_req_t  request (id, addr, mode, we, size, be, attr, wdata, last, spec).
REQ-008 mem_resp_exc  out  1  request rejected with exception; valid only in handshake cycle.
REQ-009 mem_resp_exc_code  out  6  exception cause; valid with mem_resp_exc.
REQ-010 mem_result_valid  out  1  result valid, one-cycle pulse, no back-pressure.
REQ-011 mem_result  out  x_mem_result_t  result (id, rdata, err, dbg).
REQ-012 bus_req  out  1  data-bus request.
REQ-013 bus_gnt  in  1  data-bus grant.
REQ-014 bus_addr / bus_we / bus_be / bus_wdata  out  32 / 1 / X_MEM_WIDTH/8 / X_MEM_WIDTH  bus request fields.
REQ-015 bus_rvalid  in  1  bus response valid.
REQ-016 bus_rdata / bus_err  in  X_MEM_WIDTH / 1  bus response data, bus error.

Function
REQ-017 FSM states: IDLE, REQ, RESP, RESULT; exactly one transaction outstanding.
REQ-018 mem_ready SHALL be 1 only in IDLE.
REQ-019 Handshake = mem_valid && mem_ready; on an accepted, non-excepting handshake, latch id, addr, we, be, wdata and go IDLE->REQ.
REQ-020 In REQ: bus_req=1, bus fields driven from latched values; bus_gnt=1 moves REQ->RESP; bus fields held stable while bus_req=1 and bus_gnt=0.
REQ-021 In RESP: bus_req=0; bus_rvalid=1 latches rdata/err and moves RESP->RESULT; bus_rvalid in any other state is ignored.
REQ-022 In RESULT: mem_result_valid=1 for exactly one cycle; next state IDLE.
REQ-023 mem_result.id = latched id; rdata = latched bus_rdata for loads, 0 for stores; err = latched bus_err; dbg = 0.
REQ-024 Minimum latency: handshake cycle N, bus_req cycle N+1, gnt N+1, rvalid N+2 -> mem_result_valid N+3, mem_ready N+4.
REQ-025 mem_req.spec, mode, attr, last SHALL not alter behaviour.
REQ-026 mem_resp_exc=0 and mem_resp_exc_code=0 whenever no exception handshake occurs.
REQ-027 When mem_valid=0, no state change in IDLE; mem_valid while not ready SHALL be held off without side effects.

Reset
REQ-028 rst=1 forces IDLE immediately: mem_ready=1 (once rst=0), mem_result_valid=0, bus_req=0, all latched fields 0.
REQ-029 Reset in REQ/RESP/RESULT aborts the transaction; no mem_result is produced; a late bus_rvalid after reset is ignored.

Configuration
REQ-030 Macro RVFPM_MISALIGN_CHK_EN defined: a handshake with size=1 and addr[0]=1, or size=2 and addr[1:0]!=0, SHALL assert mem_resp_exc=1 combinationally in the handshake cycle, code 4 (we=0) or 6 (we=1); FSM stays IDLE, no bus transaction, no result.
REQ-031 Macro undefined: no alignment check; mem_resp_exc tied 0; all requests forwarded to the bus unmodified.

Verification
REQ-032 Load id=3, addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> one mem_result_valid pulse, id=3, rdata=0xDEADBEEF, err=0, cycle N+3.
REQ-033 Store id=5, addr=0x204, wdata=0x12345678, be=0xF, gnt held low 3 cycles -> bus fields stable for 4 cycles, result id=5, rdata=0, err=0.
REQ-034 Load id=7 with bus_err=1 on response -> result id=7, err=1; mem_ready returns 1 next cycle.
REQ-035 With RVFPM_MISALIGN_CHK_EN: store size=2 addr=0x102 -> mem_resp_exc=1, code=6, bus_req stays 0, no result; without macro -> bus_addr=0x102 issued.
REQ-036 rst pulsed while in RESP, then bus_rvalid=1 -> no mem_result_valid, state IDLE, mem_ready=1.
REQ-037 Back-to-back: mem_valid held 1 with two requests (id=1, id=2) -> second accepted only after first result; results in order 1, 2.
